// File: rtl/ctrl_pipe.sv
// ctrl_pipe: per-stage control-word pipeline with stall, flush and bubble
// handling, plus a saturating counter of input-blocked cycles.
// Optional feature macro: CTRL_PIPE_STALLPROP_EN
//   defined   -> a stall propagates toward stage 0 and a bubble is injected
//                behind the stalled stage.
//   undefined -> each stage stalls on its own request only; downstream stages
//                keep loading from the held stage.
module ctrl_pipe #(
    parameter int WIDTH  = 19,
    parameter int STAGES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   out_ctrl,
    output logic [STAGES-1:0]         out_valid,
    output logic [15:0]               stall_cycles
);

    logic [WIDTH-1:0]  ctrl_r   [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [15:0]       stall_cnt_r;

    logic [STAGES-1:0] estall_s;
    logic [STAGES-1:0] bubble_s;
    logic [WIDTH-1:0]  feed_ctrl_s [STAGES];
    logic [STAGES-1:0] feed_valid_s;

`ifdef CTRL_PIPE_STALLPROP_EN
    // Effective stall: a held stage also holds every stage upstream of it.
    always_comb begin
        logic [STAGES-1:0] acc;
        acc = '0;
        acc[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            acc[i] = stall[i] | acc[i+1];
        end
        estall_s = acc;
    end

    // Bubble: a moving stage whose upstream neighbour holds takes an empty slot.
    always_comb begin
        bubble_s = '0;
        for (int i = 1; i < STAGES; i++) begin
            bubble_s[i] = estall_s[i-1] & ~estall_s[i];
        end
    end
`else
    // Effective stall: each stage only honours its own request.
    always_comb begin
        estall_s = stall;
    end

    // No bubble injection: the caller keeps hazards consistent.
    always_comb begin
        bubble_s = '0;
    end
`endif

    // Load source per stage: masked input for stage 0, previous stage otherwise.
    always_comb begin
        feed_ctrl_s[0]  = in_valid ? in_ctrl : {WIDTH{1'b0}};
        feed_valid_s    = '0;
        feed_valid_s[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            feed_ctrl_s[i]  = ctrl_r[i-1];
            feed_valid_s[i] = valid_r[i-1];
        end
    end

    // Stage registers: reset, then flush, then hold, then bubble, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                ctrl_r[i] <= {WIDTH{1'b0}};
            end
            valid_r <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush[i]) begin
                    ctrl_r[i]  <= {WIDTH{1'b0}};
                    valid_r[i] <= 1'b0;
                end else if (estall_s[i]) begin
                    ctrl_r[i]  <= ctrl_r[i];
                    valid_r[i] <= valid_r[i];
                end else if (bubble_s[i]) begin
                    ctrl_r[i]  <= {WIDTH{1'b0}};
                    valid_r[i] <= 1'b0;
                end else begin
                    ctrl_r[i]  <= feed_ctrl_s[i];
                    valid_r[i] <= feed_valid_s[i];
                end
            end
        end
    end

    // Saturating count of cycles in which stage 0 refused input.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (!in_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Pack stage registers onto the flat output bus.
    always_comb begin
        out_ctrl = '0;
        for (int i = 0; i < STAGES; i++) begin
            out_ctrl[i*WIDTH +: WIDTH] = ctrl_r[i];
        end
    end

    assign out_valid    = valid_r;
    assign in_ready     = ~estall_s[0];
    assign stall_cycles = stall_cnt_r;

endmodule
